decode_stage: RTL and testbench

Pipelined RV32 instruction decode stage: splits a fetched instruction into register indices, function fields and a fully generated, sign-extended immediate for every base format (I/S/B/U/J), then registers the result behind a valid/ready handshake. It sits between the fetch stage and register-file read/execute, supports back-pressure and pipeline flush, and flags unsupported opcodes. It is parametrised in instruction, immediate and PC width.

---
 rtl/decode_pkg.sv | 25 ++
 rtl/decode_if.sv | 38 +++
 rtl/decode_imm_gen.sv | 46 ++++
 rtl/decode_stage.sv | 78 +++++++
 tb/tb_decode_stage.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/decode_pkg.sv
// Shared opcode constants and immediate-format encoding for the RV32 decode stage.
package decode_pkg;

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] SYSTEM   = 7'b1110011;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] MISC_MEM = 7'b0001111;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } imm_fmt_e;

endpackage

// File: rtl/decode_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
import decode_pkg::*;

interface decode_if #(
  parameter int DW   = 32,
  parameter int XLEN = 32,
  parameter int PCW  = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_instr;
  logic [PCW-1:0]  in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [PCW-1:0]  out_pc;
  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm;
  imm_fmt_e        imm_fmt;
  logic            illegal;

  // slave = the decode stage, master = its fetch/execute neighbours
  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, opcode, rd, rs1, rs2,
           funct3, funct7, imm, imm_fmt, illegal
  );
  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, opcode, rd, rs1, rs2,
           funct3, funct7, imm, imm_fmt, illegal
  );
endinterface

// File: rtl/decode_imm_gen.sv
// Combinational opcode classifier and sign-extended immediate generator.
import decode_pkg::*;

module imm_gen #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_imm,
  output imm_fmt_e        o_fmt,
  output logic            o_illegal
);

  logic [31:0] w_raw;

  always_comb begin
    o_fmt     = FMT_R;
    o_illegal = 1'b0;
    case (i_instr[6:0])
      OP_IMM, LOAD, JALR, SYSTEM: o_fmt = FMT_I;
      STORE:                      o_fmt = FMT_S;
      BRANCH:                     o_fmt = FMT_B;
      LUI, AUIPC:                 o_fmt = FMT_U;
      JAL:                        o_fmt = FMT_J;
      OP, MISC_MEM:               o_fmt = FMT_R;
      default:                    o_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_raw = 32'd0;
    case (o_fmt)
      FMT_I: w_raw = {{20{i_instr[31]}}, i_instr[31:20]};
      FMT_S: w_raw = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      FMT_B: w_raw = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                      i_instr[30:25], i_instr[11:8], 1'b0};
      FMT_U: w_raw = {i_instr[31:12], 12'd0};
      FMT_J: w_raw = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                      i_instr[20], i_instr[30:21], 1'b0};
      default: w_raw = 32'd0;
    endcase
  end

  // signed size cast widens to XLEN by replicating bit 31
  assign o_imm = XLEN'($signed(w_raw));

endmodule

// File: rtl/decode_stage.sv
// RV32 decode stage: one output register behind a valid/ready handshake with flush.
import decode_pkg::*;

module decode_stage #(
  parameter int DW   = 32,
  parameter int XLEN = 32,
  parameter int PCW  = 32
) (
  input logic     clk,
  input logic     arst_n,
  decode_if.slave bus
);

  if (DW != 32) begin : g_bad_dw
    $error("decode_stage: DW must be 32");
  end
  if (XLEN < 32) begin : g_bad_xlen
    $error("decode_stage: XLEN must be >= 32");
  end

  logic [XLEN-1:0] w_imm;
  imm_fmt_e        w_fmt;
  logic            w_illegal;
  logic            w_accept;

  logic            r_valid;
  logic [PCW-1:0]  r_pc;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_imm;
  imm_fmt_e        r_fmt;
  logic            r_illegal;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .i_instr   (bus.in_instr),
    .o_imm     (w_imm),
    .o_fmt     (w_fmt),
    .o_illegal (w_illegal)
  );

  // out_ready feeds in_ready combinationally: no skid buffer
  assign bus.in_ready = !r_valid || bus.out_ready;
  assign w_accept     = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_valid   <= 1'b0;
      r_pc      <= '0;
      r_instr   <= '0;
      r_imm     <= '0;
      r_fmt     <= FMT_R;
      r_illegal <= 1'b0;
    end else if (bus.flush) begin
      r_valid   <= 1'b0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_pc      <= bus.in_pc;
      r_instr   <= bus.in_instr;
      r_imm     <= w_imm;
      r_fmt     <= w_fmt;
      r_illegal <= w_illegal;
    end else if (bus.out_ready) begin
      r_valid   <= 1'b0;
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.out_pc    = r_pc;
  assign bus.opcode    = r_instr[6:0];
  assign bus.rd        = r_instr[11:7];
  assign bus.funct3    = r_instr[14:12];
  assign bus.rs1       = r_instr[19:15];
  assign bus.rs2       = r_instr[24:20];
  assign bus.funct7    = r_instr[31:25];
  assign bus.imm       = r_imm;
  assign bus.imm_fmt   = r_fmt;
  assign bus.illegal   = r_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: formats, back-pressure, flush, async reset, XLEN=64 copy.
import decode_pkg::*;

module tb_decode_stage;

  logic clk = 1'b0;
  logic arst_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  decode_if #(.XLEN(32)) bus ();
  decode_if #(.XLEN(64)) bus64 ();

  decode_stage #(.DW(32), .XLEN(32), .PCW(32)) u_dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  decode_stage #(.DW(32), .XLEN(64), .PCW(32)) u_dut64 (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus64)
  );

  assign bus64.in_valid  = bus.in_valid;
  assign bus64.in_instr  = bus.in_instr;
  assign bus64.in_pc     = bus.in_pc;
  assign bus64.flush     = bus.flush;
  assign bus64.out_ready = bus.out_ready;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] pc);
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_pc    = pc;
    step();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    arst_n        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    #3;
    chk("rst_valid",   bus.out_valid, 0);
    chk("rst_imm",     bus.imm, 0);
    chk("rst_fmt",     bus.imm_fmt, FMT_R);
    chk("rst_illegal", bus.illegal, 0);
    chk("rst_pc",      bus.out_pc, 0);
    chk("rst_ready",   bus.in_ready, 1);
    #9 arst_n = 1'b1;

    // addi x1,x2,-1
    send(32'hFFF10093, 32'h100);
    chk("addi_valid", bus.out_valid, 1);
    chk("addi_rd",    bus.rd, 1);
    chk("addi_rs1",   bus.rs1, 2);
    chk("addi_imm",   bus.imm, 32'hFFFFFFFF);
    chk("addi_fmt",   bus.imm_fmt, FMT_I);
    chk("addi_ill",   bus.illegal, 0);
    chk("addi_pc",    bus.out_pc, 32'h100);
    chk("addi_imm64", bus64.imm, 64'hFFFFFFFFFFFFFFFF);

    // sw x2,8(x1)
    send(32'h0020A423, 32'h104);
    chk("sw_imm", bus.imm, 32'h8);
    chk("sw_rs1", bus.rs1, 1);
    chk("sw_rs2", bus.rs2, 2);
    chk("sw_fmt", bus.imm_fmt, FMT_S);
    chk("sw_f3",  bus.funct3, 3'b010);

    // lui x5,0x12345
    send(32'h123452B7, 32'h108);
    chk("lui_imm",   bus.imm, 32'h12345000);
    chk("lui_rd",    bus.rd, 5);
    chk("lui_fmt",   bus.imm_fmt, FMT_U);
    chk("lui_imm64", bus64.imm, 64'h12345000);

    // jal x1,-4
    send(32'hFFDFF0EF, 32'h10C);
    chk("jal_imm",   bus.imm, 32'hFFFFFFFC);
    chk("jal_rd",    bus.rd, 1);
    chk("jal_fmt",   bus.imm_fmt, FMT_J);
    chk("jal_imm64", bus64.imm, 64'hFFFFFFFFFFFFFFFC);

    // beq x1,x2,+16
    send(32'h00208863, 32'h110);
    chk("beq_imm", bus.imm, 32'h10);
    chk("beq_fmt", bus.imm_fmt, FMT_B);

    // add x3,x1,x2 : R-type, no immediate
    send(32'h002081B3, 32'h114);
    chk("add_fmt", bus.imm_fmt, FMT_R);
    chk("add_imm", bus.imm, 0);
    chk("add_ill", bus.illegal, 0);
    chk("add_rd",  bus.rd, 3);

    // all-zero word: opcode[1:0] != 2'b11
    send(32'h00000000, 32'h118);
    chk("zero_ill", bus.illegal, 1);
    chk("zero_imm", bus.imm, 0);
    chk("zero_fmt", bus.imm_fmt, FMT_R);
    chk("zero_vld", bus.out_valid, 1);

    // back-pressure: addi held while lui waits at the input
    send(32'hFFF10093, 32'h200);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h123452B7;
    bus.in_pc     = 32'h204;
    #1;
    chk("bp_ready0", bus.in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_pc",    bus.out_pc, 32'h200);
      chk("bp_imm",   bus.imm, 32'hFFFFFFFF);
      chk("bp_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    chk("bp_next_valid", bus.out_valid, 1);
    chk("bp_next_pc",    bus.out_pc, 32'h204);
    chk("bp_next_imm",   bus.imm, 32'h12345000);
    step();
    chk("drain_valid", bus.out_valid, 0);
    chk("drain_hold",  bus.imm, 32'h12345000);

    // flush while holding one and accepting another
    send(32'hFFDFF0EF, 32'h300);
    chk("fl_pre_valid", bus.out_valid, 1);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h0020A423;
    bus.in_pc    = 32'h304;
    #1;
    chk("fl_ready", bus.in_ready, 1);
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl_valid", bus.out_valid, 0);
    send(32'h0020A423, 32'h308);
    chk("fl_after_valid", bus.out_valid, 1);
    chk("fl_after_pc",    bus.out_pc, 32'h308);
    chk("fl_after_imm",   bus.imm, 32'h8);

    // async reset during a stall
    send(32'hFFF10093, 32'h400);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h123452B7;
    step();
    chk("ar_stall_valid", bus.out_valid, 1);
    #2 arst_n = 1'b0;
    #1;
    chk("ar_valid", bus.out_valid, 0);
    chk("ar_imm",   bus.imm, 0);
    chk("ar_rd",    bus.rd, 0);
    chk("ar_pc",    bus.out_pc, 0);
    chk("ar_fmt",   bus.imm_fmt, FMT_R);
    chk("ar_imm64", bus64.imm, 0);
    bus.in_valid = 1'b0;
    #2 arst_n = 1'b1;
    #1;
    chk("ar_ready", bus.in_ready, 1);
    send(32'h123452B7, 32'h500);
    chk("ar_after_valid", bus.out_valid, 1);
    chk("ar_after_rd",    bus.rd, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
